// File: rtl/traffic_pkg.sv
// Shared types and default constants for the traffic-light controller and its interval timer.
package traffic_pkg;

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_RUN    = 2'd1,
        T_EXPIRE = 2'd2
    } timer_state_t;

    localparam int DEF_PRESCALE  = 50000;
    localparam int DEF_RED_TICKS = 30;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle ticks every PRESCALE enabled cycles.
// tick is combinational so the consumer acts on the same edge at which the prescaler wraps.
module tick_prescaler #(
    parameter int PRESCALE = traffic_pkg::DEF_PRESCALE,
    parameter int PS_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps;

    assign tick = en && (ps == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps <= '0;
        end else if (clear) begin
            ps <= '0;
        end else if (en) begin
            ps <= tick ? '0 : ps + 1'b1;
        end
    end

endmodule

// File: rtl/light_timer.sv
// Interval timer answering the controller's start_timer request with a one-cycle timed pulse.
// Define LIGHT_TIMER_REMAINING_EN to expose the live tick count on the remaining port.
module light_timer
    import traffic_pkg::*;
#(
    parameter int PRESCALE  = DEF_PRESCALE,
    parameter int PS_W      = 16,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RED_TICKS = DEF_RED_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_timer,
    input  logic [CNT_W-1:0] duration,
    input  logic             hold,
    output logic             timed,
    output logic             busy
`ifdef LIGHT_TIMER_REMAINING_EN
    ,
    output logic [CNT_W-1:0] remaining
`endif
);

    timer_state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             ps_clear;
    logic             ps_en;
    logic             tick;

    assign ps_clear = (state == T_IDLE) && start_timer;
    assign ps_en    = (state == T_RUN) && !hold;

    tick_prescaler #(
        .PRESCALE(PRESCALE),
        .PS_W    (PS_W)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(ps_clear),
        .en   (ps_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= T_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt only decrements while above 1, so it reaches 0 solely on the expiring tick.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            T_IDLE: begin
                if (start_timer) begin
                    cnt_next   = (duration == '0) ? CNT_W'(RED_TICKS) : duration;
                    state_next = T_RUN;
                end
            end
            T_RUN: begin
                if (tick) begin
                    if (cnt == CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = T_EXPIRE;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
            end
            T_EXPIRE: begin
                state_next = T_IDLE;
            end
            default: begin
                state_next = T_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign timed = (state == T_EXPIRE);
    assign busy  = (state != T_IDLE);

`ifdef LIGHT_TIMER_REMAINING_EN
    assign remaining = cnt;
`endif

endmodule

// File: tb/tb_light_timer.sv
// Bench for light_timer: directed scenarios plus random traffic against a cycle-budget model.
module tb_light_timer;

    localparam int P     = 4;
    localparam int RED   = 5;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_timer = 1'b0;
    logic [CNT_W-1:0] duration = '0;
    logic             hold = 1'b0;
    logic             timed;
    logic             busy;
`ifdef LIGHT_TIMER_REMAINING_EN
    logic [CNT_W-1:0] remaining;
`endif

    light_timer #(
        .PRESCALE (P),
        .PS_W     (4),
        .CNT_W    (CNT_W),
        .RED_TICKS(RED)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .start_timer(start_timer),
        .duration   (duration),
        .hold       (hold),
        .timed      (timed),
        .busy       (busy)
`ifdef LIGHT_TIMER_REMAINING_EN
        ,
        .remaining  (remaining)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_timed_edge = -1;
    int timed_count = 0;

    // Model: a run is a budget of D*P un-held cycles; when it is spent the timer expires.
    int m_phase = 0;   // 0 idle, 1 running, 2 expiring
    int m_left  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_remaining();
        return (m_phase == 1) ? (m_left + P - 1) / P : 0;
    endfunction

    always @(posedge rst) begin
        m_phase = 0;
        m_left  = 0;
        exp_q.delete();
    end

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                0: if (start_timer) begin
                    m_left  = ((duration == 0) ? RED : int'(duration)) * P;
                    m_phase = 1;
                end
                1: if (!hold) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        exp_q.push_back(cyc);
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Monitor: compares each cycle and retires scoreboard entries on every timed pulse.
    always @(negedge clk) begin
        check("busy", busy, (m_phase != 0));
        check("timed", timed, (m_phase == 2));
`ifdef LIGHT_TIMER_REMAINING_EN
        check("remaining", remaining, model_remaining());
`endif
        if (timed) begin
            timed_count++;
            last_timed_edge = cyc;
            if (exp_q.size() == 0) begin
                check("timed_unexpected", 1, 0);
            end else begin
                check("timed_edge", cyc, exp_q.pop_front());
            end
        end
    end

    // Drives a one-cycle start; returns the edge that sampled it.
    task automatic do_start(input int d, output int e0);
        @(negedge clk);
        start_timer = 1'b1;
        duration    = CNT_W'(d);
        @(negedge clk);
        start_timer = 1'b0;
        duration    = CNT_W'($urandom_range(0, 255));
        e0 = cyc;
    endtask

    task automatic wait_edge(input int target);
        int guard = 0;
        while (cyc < target && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < target) check("wait_edge_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic pulse_reset(input int cycles);
        #2;
        rst = 1'b1;
        #1;
        check("reset_timed", timed, 0);
        check("reset_busy", busy, 0);
`ifdef LIGHT_TIMER_REMAINING_EN
        check("reset_remaining", remaining, 0);
`endif
        repeat (cycles) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int e0;
        int tc;
        repeat (2) @(negedge clk);

        pulse_reset(3);
        repeat (3) @(negedge clk);
        check("post_reset_busy", busy, 0);

        // Basic run: duration 3 expires at E0+12.
        do_start(3, e0);
        check("busy_after_start", busy, 1);
        wait_idle();
        check("d3_expiry", last_timed_edge, e0 + 12);

        // Duration 0 selects RED_TICKS.
        do_start(0, e0);
        wait_idle();
        check("d0_expiry", last_timed_edge, e0 + 20);

        // Six held cycles push expiry out by six.
        do_start(3, e0);
        wait_edge(e0 + 5);
        hold = 1'b1;
        repeat (6) @(negedge clk);
        hold = 1'b0;
        wait_idle();
        check("hold_expiry", last_timed_edge, e0 + 18);

        // Re-pulsing start mid-run is ignored.
        do_start(3, e0);
        wait_edge(e0 + 5);
        start_timer = 1'b1;
        duration    = 8'd9;
        @(negedge clk);
        start_timer = 1'b0;
        wait_idle();
        check("retrigger_expiry", last_timed_edge, e0 + 12);

        // Reset aborts a run; a following start behaves normally.
        do_start(3, e0);
        wait_edge(e0 + 6);
        tc = timed_count;
        pulse_reset(1);
        repeat (20) @(negedge clk);
        check("abort_no_timed", timed_count, tc);
        do_start(2, e0);
        wait_idle();
        check("after_abort_expiry", last_timed_edge, e0 + 8);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start_timer = ($urandom_range(0, 5) == 0);
            duration    = CNT_W'($urandom_range(0, 6));
            hold        = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
        end
        @(negedge clk);
        start_timer = 1'b0;
        hold        = 1'b0;
        wait_idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
